// File: rtl/sram_like_ram_responder_pkg.sv
// Shared types and constants for the SRAM-like RAM responder and its initiators.
package sram_like_ram_responder_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned CNT_WIDTH  = 4;
  localparam int unsigned LAT_MIN    = 1;
  localparam int unsigned LAT_MAX    = 15;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } resp_state_e;

  // Request fields captured at the address handshake
  typedef struct packed {
    logic                  wr;
    logic [1:0]            size;
    logic [1:0]            lo;
    logic [DATA_WIDTH-1:0] wdata;
  } req_s;

  function automatic logic [DATA_WIDTH-1:0] expand_mask(input logic [3:0] m);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = {8{m[i]}};
    return r;
  endfunction

endpackage

// File: rtl/sram_like_ram_responder_if.sv
// SRAM-like data bus: initiator drives the request, responder returns handshakes and read data.
interface sram_like_ram_responder_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_rdata, data_addr_ok, data_data_ok
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_rdata, data_addr_ok, data_data_ok
  );
endinterface

// File: rtl/byte_mask_gen.sv
// Byte-lane write mask from access size and low address bits; shared with the data cache merge.
module byte_mask_gen
  import sram_like_ram_responder_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] mask_c
);

  always_comb begin
    mask_c = 4'b1111;
    case (size)
      SIZE_BYTE: mask_c = 4'b0001 << addr_lo;
      SIZE_HALF: mask_c = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:   mask_c = 4'b1111;
    endcase
  end

endmodule

// File: rtl/sram_like_ram_responder.sv
// SRAM-like bus responder backed by a word RAM with a fixed response latency.
module sram_like_ram_responder
  import sram_like_ram_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  sram_like_ram_responder_if.slave    bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_latency_check
    $error("sram_like_ram_responder: LATENCY must be within 1..15");
  end

  resp_state_e            state, state_next;
  logic [CNT_WIDTH-1:0]   cnt, cnt_next;
  req_s                   req_q;
  logic [ADDR_WIDTH-1:0]  idx_q;
  logic [DATA_WIDTH-1:0]  ram [DEPTH];
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   data_ok_q;
  logic                   hs;
  logic [ADDR_WIDTH-1:0]  rd_idx;
  logic                   rd_is_read;
  logic                   rd_fire;
  logic [3:0]             mask;
  logic [DATA_WIDTH-1:0]  bit_mask;
  logic                   unused_addr_bits;

  assign unused_addr_bits = ^bus.data_addr[31:ADDR_WIDTH+2];

  assign bus.data_addr_ok = bus.data_req & (state == ST_IDLE);
  assign hs               = bus.data_addr_ok;

  // Next-state and counter
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: if (hs) begin
        cnt_next   = CNT_WIDTH'(LATENCY - 1);
        state_next = (LATENCY == 1) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        cnt_next = cnt - CNT_WIDTH'(1);
        if (cnt == CNT_WIDTH'(1)) state_next = ST_RESP;
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q <= '0;
      idx_q <= '0;
    end else if (hs) begin
      req_q <= '{wr: bus.data_wr, size: bus.data_size, lo: bus.data_addr[1:0],
                 wdata: bus.data_wdata};
      idx_q <= bus.data_addr[ADDR_WIDTH+1:2];
    end
  end

  // With LATENCY==1 RESP is entered straight from the handshake, before the latch is valid
  always_comb begin
    rd_idx     = idx_q;
    rd_is_read = ~req_q.wr;
    if (state == ST_IDLE) begin
      rd_idx     = bus.data_addr[ADDR_WIDTH+1:2];
      rd_is_read = ~bus.data_wr;
    end
    rd_fire = rd_is_read && (state_next == ST_RESP) && (state != ST_RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      data_ok_q <= (state_next == ST_RESP);
      if (rd_fire) rdata_q <= ram[rd_idx];
    end
  end

  byte_mask_gen u_mask (
    .size    (req_q.size),
    .addr_lo (req_q.lo),
    .mask_c  (mask)
  );

  assign bit_mask = expand_mask(mask);

  // RAM contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (state == ST_RESP && req_q.wr)
      ram[idx_q] <= (ram[idx_q] & ~bit_mask) | (req_q.wdata & bit_mask);
  end

  assign bus.data_rdata   = rdata_q;
  assign bus.data_data_ok = data_ok_q;

endmodule

// File: tb/tb_sram_like_ram_responder.sv
// Directed bench for the SRAM-like responder at LATENCY=2 and LATENCY=1.
module tb_sram_like_ram_responder;
  import sram_like_ram_responder_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  sram_like_ram_responder_if bus0();
  sram_like_ram_responder_if bus1();

  sram_like_ram_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut (
    .clk (clk), .rst (rst), .bus (bus0.slave)
  );

  sram_like_ram_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut_l1 (
    .clk (clk), .rst (rst), .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic req, input logic wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (sel) begin
      bus1.data_req = req; bus1.data_wr = wr; bus1.data_size = size;
      bus1.data_addr = addr; bus1.data_wdata = wdata;
    end else begin
      bus0.data_req = req; bus0.data_wr = wr; bus0.data_size = size;
      bus0.data_addr = addr; bus0.data_wdata = wdata;
    end
  endtask

  function automatic logic get_aok(input bit sel);
    return sel ? bus1.data_addr_ok : bus0.data_addr_ok;
  endfunction

  function automatic logic get_dok(input bit sel);
    return sel ? bus1.data_data_ok : bus0.data_data_ok;
  endfunction

  function automatic logic [31:0] get_rdata(input bit sel);
    return sel ? bus1.data_rdata : bus0.data_rdata;
  endfunction

  // One transaction; inputs are scrambled after the handshake to show they are latched
  task automatic run_txn(input bit sel, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output int lat);
    int k;
    @(negedge clk);
    drive(sel, 1'b1, wr, size, addr, wdata);
    #1 check("addr_ok", 32'(get_aok(sel)), 32'd1);
    @(posedge clk);
    @(negedge clk);
    drive(sel, 1'b0, ~wr, 2'b11, 32'hFFFF_FFFC, ~wdata);
    lat = 0;
    k   = 1;
    while (lat == 0 && k <= 20) begin
      if (get_dok(sel)) lat = k;
      else begin
        @(negedge clk);
        k++;
      end
    end
    rd = get_rdata(sel);
    @(negedge clk);
    check("data_ok_pulse", 32'(get_dok(sel)), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    int          hs_cnt;
    int          dok_cnt;
    int          seen;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    drive(1'b0, 1'b0, 1'b0, SIZE_WORD, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, SIZE_WORD, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    check("rst_rdata", bus0.data_rdata, 32'h0);
    check("rst_data_ok", 32'(bus0.data_data_ok), 32'd0);
    check("rst_addr_ok", 32'(bus0.data_addr_ok), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_req_data_ok", 32'(bus0.data_data_ok), 32'd0);

    // Word write then read
    run_txn(1'b0, 1'b1, SIZE_WORD, 32'h0000_0010, 32'hDEAD_BEEF, rd, lat);
    check("wr10_lat", 32'(lat), 32'd2);
    run_txn(1'b0, 1'b0, SIZE_WORD, 32'h0000_0010, 32'h0, rd, lat);
    check("rd10_lat", 32'(lat), 32'd2);
    check("rd10_data", rd, 32'hDEAD_BEEF);

    // Byte and halfword merges
    run_txn(1'b0, 1'b1, SIZE_WORD, 32'h20, 32'h1122_3344, rd, lat);
    run_txn(1'b0, 1'b1, SIZE_BYTE, 32'h21, 32'h0000_AA00, rd, lat);
    check("sb_lat", 32'(lat), 32'd2);
    run_txn(1'b0, 1'b1, SIZE_HALF, 32'h22, 32'hBBBB_0000, rd, lat);
    run_txn(1'b0, 1'b0, SIZE_WORD, 32'h20, 32'h0, rd, lat);
    check("rd20_merged", rd, 32'hBBBB_AA44);

    // Continuous request: expect handshakes every 3 cycles, single-cycle data_ok
    hs_cnt  = 0;
    dok_cnt = 0;
    bus0.data_wr   = 1'b0;
    bus0.data_size = SIZE_WORD;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus0.data_req  = 1'b1;
      bus0.data_addr = hs_cnt[0] ? 32'h20 : 32'h10;
      #1;
      check($sformatf("stream_aok%0d", i), 32'(bus0.data_addr_ok), 32'((i % 3) == 0));
      check($sformatf("stream_dok%0d", i), 32'(bus0.data_data_ok), 32'((i % 3) == 2));
      if (bus0.data_data_ok) begin
        check($sformatf("stream_rdata%0d", dok_cnt), bus0.data_rdata,
              dok_cnt[0] ? 32'hBBBB_AA44 : 32'hDEAD_BEEF);
        dok_cnt++;
      end
      if (bus0.data_addr_ok) hs_cnt++;
    end
    bus0.data_req = 1'b0;

    // Aliasing above the RAM index bits
    run_txn(1'b0, 1'b1, SIZE_WORD, 32'h0000_1004, 32'h55AA_55AA, rd, lat);
    run_txn(1'b0, 1'b0, SIZE_WORD, 32'h0000_0004, 32'h0, rd, lat);
    check("alias_rd", rd, 32'h55AA_55AA);

    // Reset while in WAIT aborts the write
    run_txn(1'b0, 1'b1, SIZE_WORD, 32'h30, 32'h0, rd, lat);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, SIZE_WORD, 32'h30, 32'hFFFF_FFFF);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus0.data_req = 1'b0;
    #1 check("midrst_rdata", bus0.data_rdata, 32'h0);
    @(negedge clk);
    rst  = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus0.data_data_ok) seen++;
    end
    check("midrst_no_data_ok", 32'(seen), 32'd0);
    check("midrst_rdata_after", bus0.data_rdata, 32'h0);
    run_txn(1'b0, 1'b0, SIZE_WORD, 32'h30, 32'h0, rd, lat);
    check("midrst_rd30", rd, 32'h0);

    // LATENCY=1 instance
    run_txn(1'b1, 1'b1, SIZE_WORD, 32'h08, 32'hCAFE_F00D, rd, lat);
    check("l1_wr_lat", 32'(lat), 32'd1);
    run_txn(1'b1, 1'b0, SIZE_WORD, 32'h08, 32'h0, rd, lat);
    check("l1_rd_lat", 32'(lat), 32'd1);
    check("l1_rd08", rd, 32'hCAFE_F00D);
    run_txn(1'b1, 1'b1, SIZE_WORD, 32'h0C, 32'h1234_5678, rd, lat);
    check("l1_rdata_hold", bus1.data_rdata, 32'hCAFE_F00D);
    run_txn(1'b1, 1'b0, SIZE_WORD, 32'h0C, 32'h0, rd, lat);
    check("l1_rd0c", rd, 32'h1234_5678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_like_ram_responder.md
Name: sram_like_ram_responder

Overview:
- Responder (slave) end of the team's SRAM-like data interface (req / wr / size / addr / wdata; addr_ok / data_ok / rdata).
- Backed by an on-chip word-addressed RAM with a fixed, parameterised response latency.
- Sits where the AXI bridge normally sits, so the data cache and the uncached path can be run and verified against a deterministic memory.
- One transaction in flight at a time.

Parameters:
- ADDR_WIDTH, 10, number of word-index bits; the RAM holds 2^ADDR_WIDTH 32-bit words.
- LATENCY, 2, cycles from the addr handshake edge to the data_ok cycle. Legal range 1..15. Values outside that range are a compile-time error.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_req  in  1  request valid from the initiator.
- data_wr  in  1  1 = write, 0 = read; sampled at the addr handshake.
- data_size  in  2  00 = byte, 01 = halfword, 10 = word; sampled at the handshake.
- data_addr  in  32  byte address; sampled at the handshake.
- data_wdata  in  32  write data, lane-aligned; sampled at the handshake.
- data_rdata  out  32  read data; valid in the data_ok cycle of a read.
- data_addr_ok  out  1  request accepted this cycle.
- data_data_ok  out  1  transaction complete this cycle.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE and the counter clears.
  - data_data_ok = 0 and data_rdata = 0.
  - The latched request registers clear.
  - RAM contents are not reset (undefined after power-up) and are preserved across reset.
- States: IDLE, WAIT, RESP.
- data_addr_ok = data_req & (state == IDLE). This output is combinational.
- Handshake: data_req & data_addr_ok at a rising edge.
  - Latch wr, size, addr index addr[ADDR_WIDTH+1:2], low bits addr[1:0], and wdata.
  - Load the counter with LATENCY-1.
  - Go to RESP if LATENCY == 1, otherwise go to WAIT.
- WAIT: the counter decrements each cycle. When the counter reaches 1, go to RESP on the next edge.
- RESP:
  - data_data_ok = 1 for exactly one cycle, which is LATENCY cycles after the handshake edge.
  - The next state is always IDLE.
  - data_addr_ok = 0 in RESP. A new request is accepted no earlier than the cycle after data_ok.
- Read:
  - data_rdata is registered on entry to RESP from RAM[index].
  - It carries the full unshifted word; byte and halfword extraction is the initiator's job.
  - data_rdata holds its value until the next read completes.
- Write:
  - RAM[index] is updated at the edge that ends RESP, using a byte mask.
  - The new word is old & ~mask | wdata & mask, with the mask expanded to bytes.
  - data_rdata is unchanged by writes.
- Byte mask:
  - size 00: one-hot on addr[1:0] (00→0001, 01→0010, 10→0100, 11→1000).
  - size 01: addr[1] ? 1100 : 0011. addr[0] is ignored.
  - size 10 or 11: 1111. Size 11 is treated as word.
- Address aliasing: bits above ADDR_WIDTH+1 are ignored, so addresses wrap modulo the RAM size.
- Input changes on data_* while in WAIT or RESP are ignored, because all values were latched at the handshake.
- A deasserted data_req in IDLE causes no state change.
- Reset mid-transaction (WAIT or RESP): the transaction is aborted, no RAM write occurs, and no data_ok is issued after reset releases.
- Back-to-back: the minimum spacing between handshakes is LATENCY+1 cycles.

Decomposition:
- Shared package:
  - size encodings SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b10.
  - Responder state encoding.
  - LATENCY legality bounds.
- Sub-module byte_mask_gen: size plus addr[1:0] in, 4-bit mask out, purely combinational. The data cache's write-hit merge reuses it so both ends agree on lane masks.

Test Plan:
- LATENCY=2. Write word 0xDEADBEEF to 0x0000_0010, then read 0x10:
  - addr_ok is high in the request cycle.
  - data_ok arrives exactly 2 cycles after each handshake.
  - The read returns 0xDEADBEEF.
- Byte and half writes:
  - Sequence: word write 0x11223344 to 0x20, then sb 0xAA at 0x21 (wdata 0x0000AA00), then sh 0xBBBB at 0x22 (wdata 0xBBBB0000).
  - A read of 0x20 then returns 0xBBBBAA44.
- Hold data_req high continuously with alternating addresses:
  - addr_ok is never asserted in WAIT or RESP.
  - Handshakes are spaced exactly LATENCY+1 cycles apart.
  - Each data_ok is a single-cycle pulse.
- Aliasing with ADDR_WIDTH=10:
  - Write 0x55AA55AA to 0x0000_1004.
  - A read of 0x0000_0004 returns 0x55AA55AA.
- Reset in WAIT:
  - Write 0x0 to 0x30, then issue a write of 0xFFFFFFFF to 0x30.
  - Drop rst one cycle after the handshake and release it.
  - No data_ok is issued, data_rdata = 0, and a later read of 0x30 returns 0x0.
- LATENCY=1 build:
  - Read data_ok arrives in the cycle after the handshake.
  - data_rdata is stable until the next read completes, including across an intervening write.
